// File: rtl/comparador_pkg.sv
// Shared encodings for the MSB-first serial comparator: FSM states and relation codes.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'b00,
    GT = 2'b01,
    LT = 2'b10
  } rel_t;

endpackage

// File: rtl/celda_izq_der.sv
// Left-to-right comparator cell plus its gate primitives; purely combinational, no backpressure.
// rel code: 00 = equal so far, 01 = A greater, 10 = A less; a decided relation is absorbing.

module inversor (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module Comp_AND (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module Comp_OR (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module celda_izq_der (
  input  logic [1:0] rel_in,
  input  logic       A,
  input  logic       B,
  output logic [1:0] rel_out
);
  logic decided, undecided;
  logic a_n, b_n;
  logic a_and_bn, an_and_b;
  logic gt_new, lt_new;

  // Only an undecided (EQ) prefix may be overturned by the current bit pair.
  Comp_OR  u_or_dec  (.a(rel_in[0]), .b(rel_in[1]), .y(decided));
  inversor u_inv_dec (.a(decided),   .y(undecided));
  inversor u_inv_a   (.a(A),         .y(a_n));
  inversor u_inv_b   (.a(B),         .y(b_n));

  Comp_AND u_and_ab  (.a(A),         .b(b_n),      .y(a_and_bn));
  Comp_AND u_and_gt  (.a(undecided), .b(a_and_bn), .y(gt_new));
  Comp_AND u_and_ba  (.a(a_n),       .b(B),        .y(an_and_b));
  Comp_AND u_and_lt  (.a(undecided), .b(an_and_b), .y(lt_new));

  Comp_OR  u_or_gt   (.a(rel_in[0]), .b(gt_new),   .y(rel_out[0]));
  Comp_OR  u_or_lt   (.a(rel_in[1]), .b(lt_new),   .y(rel_out[1]));
endmodule

// File: rtl/comparador_serial_izq_der.sv
// MSB-first serial comparator: one bit pair per accepted beat, done pulses the cycle after beat N.
// Backpressure: bit_ready is high throughout RUN; bit_valid=0 stalls with counter and relation held.
module comparador_serial_izq_der
  import comparador_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic a_gt_b,
  output logic a_eq_b,
  output logic a_lt_b
);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rel_t            rel_q, rel_d;
  logic            done_q, done_d;
  logic            gt_q, gt_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;

  logic [1:0]      rel_cell;
  rel_t            rel_nxt;
  logic            last_beat;

  celda_izq_der u_celda (
    .rel_in (rel_q),
    .A      (a_bit),
    .B      (b_bit),
    .rel_out(rel_cell)
  );

  assign rel_nxt   = rel_t'(rel_cell);
  assign last_beat = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          rel_d   = EQ;
        end
      end
      RUN: begin
        if (bit_valid) begin
          rel_d = rel_nxt;
          // The counter parks at N-1 on the final beat instead of wrapping.
          if (last_beat) begin
            state_d = DONE;
            done_d  = 1'b1;
            gt_d    = (rel_nxt == GT);
            eq_d    = (rel_nxt == EQ);
            lt_d    = (rel_nxt == LT);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rel_q   <= EQ;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign bit_ready = (state_q == RUN);
  assign done      = done_q;
  assign a_gt_b    = gt_q;
  assign a_eq_b    = eq_q;
  assign a_lt_b    = lt_q;

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Randomized bench for the serial comparator; expected results come from whole-word and prefix arithmetic.
module tb_comparador_serial_izq_der;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst, start, bit_valid, a_bit, b_bit;
  logic bit_ready, busy, done, a_gt_b, a_eq_b, a_lt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic exp_gt, exp_eq, exp_lt;

  comparador_serial_izq_der #(.N(N), .CW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_valid(bit_valid),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .bit_ready(bit_ready),
    .busy     (busy),
    .done     (done),
    .a_gt_b   (a_gt_b),
    .a_eq_b   (a_eq_b),
    .a_lt_b   (a_lt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Relation of the top k bits of a versus b: 0 equal, 1 greater, 2 less.
  function automatic logic [1:0] prefix_rel(input logic [N-1:0] a, input logic [N-1:0] b, input int k);
    int unsigned pa, pb;
    pa = 32'(a) >> (N - k);
    pb = 32'(b) >> (N - k);
    if (pa > pb) return 2'd1;
    if (pa < pb) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_flags(input string tag);
    check(tag, {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, exp_gt, exp_eq, exp_lt});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start     = 1'b0;
      bit_valid = 1'($urandom % 2);
      a_bit     = 1'($urandom % 2);
      b_bit     = 1'($urandom % 2);
      @(posedge clk); #1;
      check("idle_done", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_rdy", bit_ready, 1'b0);
      check_flags("idle_flags");
    end
  endtask

  // One comparison: n_stalls invalid cycles scattered before the last beat; abort_after>=0 resets after that many beats.
  task automatic run_word(input logic [N-1:0] a, input logic [N-1:0] b, input int n_stalls,
                          input bit poke_start, input int abort_after);
    bit vpat[64];
    int total, k, j;
    bit tmp;
    total = N + n_stalls;
    for (int i = 0; i < total - 1; i++) vpat[i] = (i < N - 1);
    vpat[total-1] = 1'b1;
    for (int i = total - 2; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = vpat[i]; vpat[i] = vpat[j]; vpat[j] = tmp;
    end

    @(negedge clk);
    start     = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk); #1;
    check("start_busy", busy, 1'b1);
    check("start_rdy", bit_ready, 1'b1);
    check("start_done", done, 1'b0);
    check_flags("run_flags");

    k = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      start     = poke_start ? 1'($urandom % 2) : 1'b0;
      bit_valid = vpat[c];
      if (vpat[c]) begin
        a_bit = a[N-1-k];
        b_bit = b[N-1-k];
      end else begin
        a_bit = 1'($urandom % 2);
        b_bit = 1'($urandom % 2);
      end
      @(posedge clk); #1;
      if (vpat[c]) k++;
      if (k < N) begin
        check("run_busy", busy, 1'b1);
        check("run_done", done, 1'b0);
        check_flags("run_hold");
        check("prefix_rel", dut.rel_q, prefix_rel(a, b, k == 0 ? N : k) & {2{k != 0}});
      end
      if (abort_after >= 0 && k == abort_after) begin
        @(negedge clk);
        rst       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 1'b0);
        check("abort_rdy", bit_ready, 1'b0);
        check("abort_done", done, 1'b0);
        exp_gt = 1'b0; exp_eq = 1'b1; exp_lt = 1'b0;
        check_flags("abort_flags");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end

    exp_gt = (a > b);
    exp_eq = (a == b);
    exp_lt = (a < b);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_rdy", bit_ready, 1'b0);
    check_flags("result");
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rdy", bit_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flags", {29'd0, a_gt_b, a_eq_b, a_lt_b}, 32'b010);
    exp_gt = 1'b0; exp_eq = 1'b1; exp_lt = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    idle(3);
    run_word(8'hA5, 8'h3C, 0, 1'b0, 3);
    run_word(8'h5A, 8'h5A, 0, 1'b0, -1);
    idle(2);
    run_word(8'h80, 8'h7F, 0, 1'b0, -1);
    idle(1);
    run_word(8'h3C, 8'h3D, 0, 1'b0, -1);
    idle(1);
    run_word(8'hF0, 8'h0F, 4, 1'b0, -1);
    idle(1);
    run_word(8'hFF, 8'hFF, 0, 1'b0, -1);
    run_word(8'h01, 8'h02, 0, 1'b0, -1);
    idle(2);
    run_word(8'hC3, 8'hC7, 2, 1'b1, -1);
    idle(1);

    for (int t = 0; t < 24; t++) begin
      ra = N'($urandom);
      rb = ($urandom % 4 == 0) ? ra : N'($urandom);
      run_word(ra, rb, $urandom_range(0, 3), 1'($urandom % 2), -1);
      if ($urandom % 2) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
